// File: rtl/blit_pkg.sv
// Shared constants, mode encoding and FSM state type for the sprite blitter.
// Imported by fb_addr_calc and sprite_blitter.
package blit_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  localparam logic [7:0] TRANSPARENT_IDX = 8'h00;

  localparam logic MODE_FILL = 1'b0;
  localparam logic MODE_COPY = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fb_addr_calc.sv
// Framebuffer linear address from on-screen x/y: y*640 + x, shift-add only.
// Ports: i_x (10b screen x), i_y (9b screen y), o_addr (19b word address).
module fb_addr_calc
  import blit_pkg::*;
(
  input  logic [9:0]  i_x,
  input  logic [8:0]  i_y,
  output logic [18:0] o_addr
);

  logic [18:0] w_y512;
  logic [18:0] w_y128;

  // 640 = 512 + 128
  assign w_y512 = {1'b0, i_y, 9'd0};
  assign w_y128 = {3'b0, i_y, 7'd0};

  assign o_addr = w_y512 + w_y128 + {9'd0, i_x};

endmodule

// File: rtl/sprite_blitter.sv
// Rectangle fill / sprite copy engine writing a 640x480 8-bit framebuffer.
// Ports: clock/reset_n, command (start,mode,x_in,y_in,w_in,h_in,color_in,
// spr_base), status (busy,done), sprite ROM (spr_addr,spr_data),
// framebuffer write (fb_addr,fb_data,fb_we,fb_ready).
module sprite_blitter
  import blit_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        mode,
  input  logic [9:0]  x_in,
  input  logic [8:0]  y_in,
  input  logic [9:0]  w_in,
  input  logic [8:0]  h_in,
  input  logic [7:0]  color_in,
  input  logic [15:0] spr_base,
  output logic        busy,
  output logic        done,
  output logic [15:0] spr_addr,
  input  logic [7:0]  spr_data,
  output logic [18:0] fb_addr,
  output logic [7:0]  fb_data,
  output logic        fb_we,
  input  logic        fb_ready
);

  state_t      r_state;
  logic        r_mode;
  logic [9:0]  r_x;
  logic [8:0]  r_y;
  logic [9:0]  r_w;
  logic [8:0]  r_h;
  logic [7:0]  r_color;
  logic [9:0]  r_col;
  logic [8:0]  r_row;
  logic [15:0] r_spr_addr;

  logic [10:0] w_sx;
  logic [9:0]  w_sy;
  logic [7:0]  w_pix;
  logic        w_on;
  logic        w_opaque;
  logic        w_wr;
  logic        w_adv;
  logic        w_col_end;
  logic        w_row_end;
  logic        w_last;
  logic [18:0] w_addr;

  // Widened sums: a rectangle hanging off the right/bottom edge
  // must stay off-screen instead of wrapping to column/row 0.
  assign w_sx = {1'b0, r_x} + {1'b0, r_col};
  assign w_sy = {1'b0, r_y} + {1'b0, r_row};

  assign w_pix = (r_mode == MODE_COPY) ? spr_data : r_color;

  assign w_on = (w_sx < 11'(SCREEN_W))
             && (w_sy < 10'(SCREEN_H));

  assign w_opaque = !((r_mode == MODE_COPY)
                   && (w_pix == TRANSPARENT_IDX));

  assign w_wr = (r_state == ST_WRITE) && w_on && w_opaque;

  // Skipped pixels retire at once; written ones wait for fb_ready.
  assign w_adv = (r_state == ST_WRITE) && (!w_wr || fb_ready);

  assign w_col_end = (r_col == r_w - 10'd1);
  assign w_row_end = (r_row == r_h - 9'd1);
  assign w_last    = w_col_end && w_row_end;

  fb_addr_calc u_addr (
    .i_x    (w_sx[9:0]),
    .i_y    (w_sy[8:0]),
    .o_addr (w_addr)
  );

  assign fb_we    = w_wr;
  assign fb_addr  = w_wr ? w_addr : '0;
  assign fb_data  = w_wr ? w_pix : '0;
  assign busy     = (r_state != ST_IDLE);
  assign done     = (r_state == ST_DONE);
  assign spr_addr = r_spr_addr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_mode     <= MODE_FILL;
      r_x        <= '0;
      r_y        <= '0;
      r_w        <= '0;
      r_h        <= '0;
      r_color    <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_spr_addr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mode     <= mode;
            r_x        <= x_in;
            r_y        <= y_in;
            r_w        <= w_in;
            r_h        <= h_in;
            r_color    <= color_in;
            r_col      <= '0;
            r_row      <= '0;
            r_spr_addr <= spr_base;
            if ((w_in == '0) || (h_in == '0))
              r_state <= ST_DONE;
            else if (mode == MODE_COPY)
              r_state <= ST_READ;
            else
              r_state <= ST_WRITE;
          end
        end
        ST_READ: begin
          r_state <= ST_WRITE;
        end
        ST_WRITE: begin
          if (w_adv) begin
            if (w_last) begin
              r_state <= ST_DONE;
            end else begin
              // Row-major walk; the ROM pointer just counts,
              // which equals base + row*w + col.
              r_spr_addr <= r_spr_addr + 16'd1;
              if (w_col_end) begin
                r_col <= '0;
                r_row <= r_row + 9'd1;
              end else begin
                r_col <= r_col + 10'd1;
              end
              r_state <= (r_mode == MODE_COPY) ? ST_READ : ST_WRITE;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter: write scoreboard plus
// directed checks for latency, clipping, stalls, busy-ignore and reset.
module tb_sprite_blitter;

  logic        clock    = 1'b0;
  logic        reset_n  = 1'b0;
  logic        start    = 1'b0;
  logic        mode     = 1'b0;
  logic [9:0]  x_in     = '0;
  logic [8:0]  y_in     = '0;
  logic [9:0]  w_in     = '0;
  logic [8:0]  h_in     = '0;
  logic [7:0]  color_in = '0;
  logic [15:0] spr_base = '0;
  logic        busy;
  logic        done;
  logic [15:0] spr_addr;
  logic [7:0]  spr_data = '0;
  logic [18:0] fb_addr;
  logic [7:0]  fb_data;
  logic        fb_we;
  logic        fb_ready = 1'b1;

  typedef struct {
    logic [18:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t         exp_q[$];
  logic [15:0] spr_log[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_xfer = 0;
  int last_wr_cyc = 0;
  int done_cyc = 0;

  sprite_blitter dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .mode     (mode),
    .x_in     (x_in),
    .y_in     (y_in),
    .w_in     (w_in),
    .h_in     (h_in),
    .color_in (color_in),
    .spr_base (spr_base),
    .busy     (busy),
    .done     (done),
    .spr_addr (spr_addr),
    .spr_data (spr_data),
    .fb_addr  (fb_addr),
    .fb_data  (fb_data),
    .fb_we    (fb_we),
    .fb_ready (fb_ready)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [7:0] rom_val(input logic [15:0] a);
    if (a == 16'h0100) return 8'h00;
    if (a == 16'h0101) return 8'h33;
    return a[7:0] ^ 8'h5A;
  endfunction

  always @(posedge clock) spr_data <= rom_val(spr_addr);

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin : mon
    wr_t e;
    if (reset_n) begin
      if (busy && (spr_log.size() == 0 || spr_log[$] != spr_addr))
        spr_log.push_back(spr_addr);
      if (done) done_cyc = cyc;
      if (fb_we && fb_ready) begin
        n_xfer++;
        last_wr_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("wr_unexpected", 32'(fb_addr), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(fb_addr), 32'(e.a));
          check("wr_data", 32'(fb_data), 32'(e.d));
        end
      end
    end
  end

  task automatic push_rect(input logic m, input int x, input int y,
                           input int w, input int h,
                           input logic [7:0] c, input logic [15:0] base);
    wr_t         e;
    logic [7:0]  p;
    logic [15:0] ad;
    for (int r = 0; r < h; r++) begin
      for (int k = 0; k < w; k++) begin
        ad = base + 16'(r * w + k);
        p = m ? rom_val(ad) : c;
        if ((x + k) < 640 && (y + r) < 480 && !(m && p == 8'h00)) begin
          e.a = 19'((y + r) * 640 + (x + k));
          e.d = p;
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic set_cmd(input logic m, input int x, input int y,
                         input int w, input int h,
                         input logic [7:0] c, input logic [15:0] base);
    mode = m;
    x_in = 10'(x);
    y_in = 9'(y);
    w_in = 10'(w);
    h_in = 9'(h);
    color_in = c;
    spr_base = base;
  endtask

  task automatic run(input string tag, input logic m,
                     input int x, input int y, input int w, input int h,
                     input logic [7:0] c, input logic [15:0] base,
                     input int exp_busy);
    int bcnt = 0;
    int dcnt = 0;
    int kd = -1;
    bit fin = 0;
    push_rect(m, x, y, w, h, c, base);
    @(negedge clock);
    #1;
    set_cmd(m, x, y, w, h, c, base);
    start = 1'b1;
    for (int k = 0; k < 300 && !fin; k++) begin
      @(negedge clock);
      if (k == 0) start = 1'b0;
      if (busy) bcnt++;
      if (done) begin
        dcnt++;
        if (kd < 0) kd = k;
      end
      if (!busy && k > 0) fin = 1;
    end
    if (!fin) check({tag, "_timeout"}, 0, 1);
    check({tag, "_busy"}, 32'(bcnt), 32'(exp_busy));
    check({tag, "_done_cnt"}, 32'(dcnt), 1);
    check({tag, "_left"}, 32'(exp_q.size()), 0);
    if (w == 0 || h == 0) check({tag, "_done_lat"}, 32'(kd), 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int xf0;
    bit fin;

    repeat (2) @(negedge clock);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_we", 32'(fb_we), 0);
    check("rst_addr", 32'(fb_addr), 0);
    check("rst_data", 32'(fb_data), 0);
    check("rst_spr", 32'(spr_addr), 0);
    #1 reset_n = 1'b1;

    run("fill2x2", 1'b0, 0, 0, 2, 2, 8'h1F, 16'h0, 5);
    check("fill2x2_done_lat", 32'(done_cyc - last_wr_cyc), 1);

    spr_log.delete();
    run("copy2x1", 1'b1, 10, 1, 2, 1, 8'h00, 16'h0100, 5);
    check("copy_spr_n", 32'(spr_log.size()), 2);
    if (spr_log.size() == 2) begin
      check("copy_spr0", 32'(spr_log[0]), 32'h100);
      check("copy_spr1", 32'(spr_log[1]), 32'h101);
    end

    run("clip", 1'b0, 638, 479, 4, 2, 8'hC3, 16'h0, 9);
    run("wrap", 1'b1, 600, 100, 3, 2, 8'h00, 16'hFFFE, 13);
    run("zero_w", 1'b0, 5, 5, 0, 3, 8'h11, 16'h0, 1);

    // backpressure: fb_ready low for three cycles
    push_rect(1'b0, 5, 5, 1, 1, 8'hAA, 16'h0);
    xf0 = n_xfer;
    @(negedge clock);
    #1;
    fb_ready = 1'b0;
    set_cmd(1'b0, 5, 5, 1, 1, 8'hAA, 16'h0);
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (i == 0) start = 1'b0;
      check("stall_we", 32'(fb_we), 1);
      check("stall_addr", 32'(fb_addr), 32'd3205);
      check("stall_data", 32'(fb_data), 32'hAA);
      if (i == 2) begin
        @(posedge clock);
        #1 fb_ready = 1'b1;
      end
    end
    @(negedge clock);
    check("stall_done", 32'(done), 1);
    @(negedge clock);
    check("stall_idle", 32'(busy), 0);
    check("stall_xfers", 32'(n_xfer - xf0), 1);

    // start held through a busy command must not retrigger or relatch
    push_rect(1'b0, 100, 0, 2, 1, 8'h44, 16'h0);
    xf0 = n_xfer;
    @(negedge clock);
    #1;
    set_cmd(1'b0, 100, 0, 2, 1, 8'h44, 16'h0);
    start = 1'b1;
    @(negedge clock);
    #1;
    set_cmd(1'b0, 200, 3, 5, 2, 8'h55, 16'h0);
    @(negedge clock);
    #1 start = 1'b0;
    fin = 0;
    for (int k = 0; k < 50 && !fin; k++) begin
      @(negedge clock);
      if (!busy) fin = 1;
    end
    if (!fin) check("ignore_timeout", 0, 1);
    @(negedge clock);
    check("ignore_idle", 32'(busy), 0);
    check("ignore_xfers", 32'(n_xfer - xf0), 2);
    check("ignore_left", 32'(exp_q.size()), 0);

    // asynchronous reset in the middle of a 4x4 fill
    push_rect(1'b0, 0, 0, 4, 4, 8'h77, 16'h0);
    @(negedge clock);
    #1;
    set_cmd(1'b0, 0, 0, 4, 4, 8'h77, 16'h0);
    start = 1'b1;
    @(negedge clock);
    #1 start = 1'b0;
    @(negedge clock);
    check("pre_rst_busy", 32'(busy), 1);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_we", 32'(fb_we), 0);
    check("mid_rst_addr", 32'(fb_addr), 0);
    check("mid_rst_data", 32'(fb_data), 0);
    check("mid_rst_spr", 32'(spr_addr), 0);
    exp_q.delete();
    @(negedge clock);
    #1 reset_n = 1'b1;
    run("post_rst", 1'b0, 3, 2, 1, 1, 8'h09, 16'h0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
